axis_frame_len_fifo: RTL and testbench

Parametrised successor to the single-register frame length monitor. It passively snoops an AXI-Stream link, measures each frame's byte length, and classifies the frame against runt and oversize limits. It queues per-frame length records in a small FIFO with a valid/ready output, so back-to-back short frames are not lost. It sits beside MAC/FIFO datapaths and feeds statistics and host-visible counters.

---
 rtl/axis_frame_len_fifo.sv | 87 ++++++++
 tb/tb_axis_frame_len_fifo.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/axis_frame_len_fifo.sv
// axis_frame_len_fifo: passive AXI-Stream frame length monitor with a record FIFO
module axis_frame_len_fifo #(
   parameter int DATA_WIDTH  = 64,
   parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
   parameter int LEN_WIDTH   = 16,
   parameter int DEPTH       = 4,
   parameter int MIN_LEN     = 64,
   parameter int MAX_LEN     = 1518
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [KEEP_WIDTH-1:0] monitor_axis_tkeep,
   input  logic                  monitor_axis_tvalid,
   input  logic                  monitor_axis_tready,
   input  logic                  monitor_axis_tlast,
   output logic [LEN_WIDTH-1:0]  m_len_tdata,
   output logic [2:0]            m_len_tuser,
   output logic                  m_len_tvalid,
   input  logic                  m_len_tready,
   output logic                  frame_active,
   output logic [31:0]           frame_count,
   output logic [15:0]           drop_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [LEN_WIDTH:0] LMAX = {1'b0, {LEN_WIDTH{1'b1}}};
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   logic [LEN_WIDTH:0]   acc, pop, inc, sum, sum_sat;
   logic                 sat, ovf, sat_now, beat, last, pop_f, full, push, drop;
   logic [LEN_WIDTH-1:0] len;
   logic [LEN_WIDTH+2:0] rec;
   logic [LEN_WIDTH+2:0] mem [DEPTH];
   logic [AW-1:0]        wr, rd;
   logic [AW:0]          cnt;

   // byte count of this beat, saturating length and the record it would produce
   always_comb begin
      pop = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) pop = pop + (LEN_WIDTH + 1)'(monitor_axis_tkeep[i]);
      inc = KEEP_ENABLE ? pop : (LEN_WIDTH + 1)'(1);
      sum = acc + inc;
      ovf = sum > LMAX;
      sum_sat = ovf ? LMAX : sum;
      sat_now = sat | ovf;
      len = sum_sat[LEN_WIDTH-1:0];
      rec = {sat_now, (32'(len) > 32'(MAX_LEN)) | sat_now, 32'(len) < 32'(MIN_LEN), len};
      beat = monitor_axis_tvalid && monitor_axis_tready;
      last = beat && monitor_axis_tlast;
      pop_f = m_len_tvalid && m_len_tready;
      full = cnt == FULL;
      push = last && (!full || pop_f);
      drop = last && full && !pop_f;
      m_len_tvalid = cnt != '0;
      {m_len_tuser, m_len_tdata} = m_len_tvalid ? mem[rd] : '0;
   end

   // record storage; contents are only observed through the valid-gated head
   always_ff @(posedge clk) begin
      if (push) mem[wr] <= rec;
   end

   // frame accumulator, FIFO pointers and statistics counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc          <= '0;
         sat          <= 1'b0;
         frame_active <= 1'b0;
         wr           <= '0;
         rd           <= '0;
         cnt          <= '0;
         frame_count  <= '0;
         drop_count   <= '0;
      end else begin
         if (beat) begin
            acc          <= last ? '0 : sum_sat;
            sat          <= last ? 1'b0 : sat_now;
            frame_active <= !monitor_axis_tlast;
         end
         if (push) wr <= wr + 1'b1;
         if (pop_f) rd <= rd + 1'b1;
         cnt         <= cnt + (AW + 1)'(push) - (AW + 1)'(pop_f);
         frame_count <= frame_count + 32'(last);
         drop_count  <= drop_count + 16'(drop && drop_count != 16'hFFFF);
      end
   end
endmodule

// File: tb/tb_axis_frame_len_fifo.sv
// tb_axis_frame_len_fifo: scoreboard bench for the frame length record FIFO
module tb_axis_frame_len_fifo;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [7:0] k0 = '0, k1 = '0, k2 = '0;
   logic v0 = 0, r0 = 0, t0 = 0, v1 = 0, r1 = 0, t1 = 0, v2 = 0, r2 = 0, t2 = 0;
   logic rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
   logic [15:0] d0, d2, dc0, dc1, dc2;
   logic [7:0]  d1;
   logic [2:0]  s0, s1, s2;
   logic        q0, q1, q2, a0, a1, a2;
   logic [31:0] fc0, fc1, fc2;
   int total = 0, bad = 0;
   int macc = 0, fc_exp = 0;
   bit msat = 0, store = 1;
   logic [18:0] exp_q[$];

   always #5 clk = ~clk;

   axis_frame_len_fifo u_dut0 (
      .clk(clk), .rst(rst), .monitor_axis_tkeep(k0), .monitor_axis_tvalid(v0),
      .monitor_axis_tready(r0), .monitor_axis_tlast(t0), .m_len_tdata(d0), .m_len_tuser(s0),
      .m_len_tvalid(q0), .m_len_tready(rdy0), .frame_active(a0), .frame_count(fc0),
      .drop_count(dc0));

   axis_frame_len_fifo #(.LEN_WIDTH(8)) u_dut1 (
      .clk(clk), .rst(rst), .monitor_axis_tkeep(k1), .monitor_axis_tvalid(v1),
      .monitor_axis_tready(r1), .monitor_axis_tlast(t1), .m_len_tdata(d1), .m_len_tuser(s1),
      .m_len_tvalid(q1), .m_len_tready(rdy1), .frame_active(a1), .frame_count(fc1),
      .drop_count(dc1));

   axis_frame_len_fifo #(.KEEP_ENABLE(0)) u_dut2 (
      .clk(clk), .rst(rst), .monitor_axis_tkeep(k2), .monitor_axis_tvalid(v2),
      .monitor_axis_tready(r2), .monitor_axis_tlast(t2), .m_len_tdata(d2), .m_len_tuser(s2),
      .m_len_tvalid(q2), .m_len_tready(rdy2), .frame_active(a2), .frame_count(fc2),
      .drop_count(dc2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic beat0(input logic [7:0] k, input logic l);
      k0 = k; v0 = 1; r0 = 1; t0 = l;
      macc += $countones(k);
      if (macc > 65535) begin macc = 65535; msat = 1; end
      if (l) begin
         if (store) exp_q.push_back({msat, (macc > 1518) | msat, macc < 64, 16'(macc)});
         macc = 0; msat = 0; fc_exp++;
      end
      @(posedge clk); #1;
      v0 = 0; t0 = 0;
   endtask

   task automatic drain;
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      #1 chk("drain", exp_q.size(), 0);
   endtask

   // compare each record as the consumer takes it
   always @(negedge clk) begin
      if (!rst && q0 && rdy0) begin
         if (exp_q.size() == 0) chk("underflow", 1, 0);
         else chk("rec0", {13'd0, s0, d0}, {13'd0, exp_q.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic act;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", q0, 0); chk("rst_data", d0, 0); chk("rst_user", s0, 0);
      chk("rst_fc", fc0, 0); chk("rst_dc", dc0, 0); chk("rst_act", a0, 0);
      rst = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         beat0(8'hFF, 0);
         chk("act_mid", a0, 1);
      end
      chk("pre_valid", q0, 0);
      beat0(8'h0F, 1);
      chk("lat_valid", q0, 1);
      chk("fc_first", fc0, fc_exp);
      chk("act_clr", a0, 0);
      drain;
      beat0(8'h01, 1);
      chk("single_act", a0, 0);
      beat0(8'hA5, 1);
      drain;
      for (int i = 0; i < 199; i++) beat0(8'hFF, 0);
      beat0(8'hFF, 1);
      drain;
      chk("fc_big", fc0, fc_exp);
      rdy0 = 0;
      beat0(8'h01, 1); beat0(8'h03, 1); beat0(8'h07, 1); beat0(8'h0F, 1);
      store = 0;
      beat0(8'h1F, 1); beat0(8'h3F, 1);
      store = 1;
      chk("drop2", dc0, 2);
      chk("fc_drop", fc0, fc_exp);
      @(posedge clk); #1;
      chk("hold_data", d0, 1);
      chk("hold_valid", q0, 1);
      rdy0 = 1;
      beat0(8'hFF, 1);
      chk("no_drop", dc0, 2);
      drain;
      for (int i = 0; i < 3; i++) beat0(8'hFF, 0);
      #2 rst = 1;
      #1;
      chk("arst_valid", q0, 0); chk("arst_data", d0, 0); chk("arst_user", s0, 0);
      chk("arst_fc", fc0, 0); chk("arst_dc", dc0, 0); chk("arst_act", a0, 0);
      macc = 0; msat = 0; fc_exp = 0;
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;
      beat0(8'hFF, 0);
      beat0(8'hFF, 1);
      drain;
      chk("fc_post", fc0, 1);
      for (int i = 0; i < 38; i++) begin
         k1 = (i == 37) ? 8'h0F : 8'hFF; t1 = (i == 37); v1 = 1; r1 = 1;
         @(posedge clk); #1;
      end
      v1 = 0; t1 = 0;
      chk("sat_len", d1, 255); chk("sat_user", s1, 3'b110); chk("sat_valid", q1, 1);
      chk("sat_fc", fc1, 1); chk("sat_dc", dc1, 0); chk("sat_act", a1, 0);
      act = 0;
      for (int i = 0; i < 9; i++) begin
         logic [2:0] p;
         logic [26:0] tbl;
         tbl = {3'b110, 3'b010, 3'b100, 3'b110, 3'b110, 3'b000, 3'b110, 3'b101, 3'b111};
         p = tbl[26 - 3 * i -: 3];
         {v2, r2, t2} = p;
         k2 = 8'($urandom);
         @(posedge clk); #1;
         if (p[2] && p[1]) act = !p[0];
         chk("kb_act", a2, act);
      end
      v2 = 0; r2 = 0; t2 = 0;
      chk("kb_len", d2, 5); chk("kb_user", s2, 3'b001); chk("kb_valid", q2, 1);
      chk("kb_fc", fc2, 1); chk("kb_dc", dc2, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
